// File: rtl/adder_pipe_acc.sv
// Registered add/sub/accumulate/load stage with ready/valid handshaking.
// The stage holds one result, and has optional saturation and a saturating count of handshakes.

module adder_pipe_acc_alu #(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_in0,
    input  logic [WIDTH-1:0] i_in1,
    input  logic [WIDTH-1:0] i_acc,
    output logic [WIDTH-1:0] o_res,
    output logic             o_carry
);
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ACC  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;
    localparam bit SAT = (SATURATE != 0);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_add_a;
    logic [WIDTH-1:0] w_add_b;

    // ACC reuses the adder with the accumulator as the left operand.
    assign w_add_a = (i_op == OP_ACC) ? i_acc : i_in0;
    assign w_add_b = (i_op == OP_ACC) ? i_in0 : i_in1;
    assign w_sum   = {1'b0, w_add_a} + {1'b0, w_add_b};
    assign w_diff  = {1'b0, i_in0} - {1'b0, i_in1};

    always_comb begin
        o_res   = i_in0;
        o_carry = 1'b0;
        case (i_op)
            OP_ADD, OP_ACC: begin
                o_carry = w_sum[WIDTH];
                o_res   = (SAT && w_sum[WIDTH]) ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
            end
            OP_SUB: begin
                o_carry = w_diff[WIDTH];
                o_res   = (SAT && w_diff[WIDTH]) ? {WIDTH{1'b0}} : w_diff[WIDTH-1:0];
            end
            OP_LOAD: begin
                o_carry = 1'b0;
                o_res   = i_in0;
            end
            default: begin
                o_carry = 1'b0;
                o_res   = i_in0;
            end
        endcase
    end
endmodule

module adder_pipe_acc #(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in0,
    input  logic [WIDTH-1:0] io_in1,
    input  logic [1:0]       io_op,
    input  logic             io_clear,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out,
    output logic             io_carry,
    output logic             io_ovf,
    output logic [WIDTH-1:0] io_acc,
    output logic [CNT_W-1:0] io_count
);
    localparam logic [1:0]       OP_ACC  = 2'b10;
    localparam logic [1:0]       OP_LOAD = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out;
    logic             r_carry;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_count;

    logic             w_accept;
    logic             w_out_hs;
    logic             w_clr;
    logic             w_acc_wr;
    logic [WIDTH-1:0] w_acc_opnd;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;

    assign io_in_ready = !r_out_valid || io_out_ready;
    assign w_accept    = io_in_valid && io_in_ready;
    assign w_out_hs    = r_out_valid && io_out_ready;
    // Clear is qualified by io_in_valid: with no operation offered, nothing changes.
    assign w_clr       = io_clear && io_in_valid;
    assign w_acc_wr    = w_accept && ((io_op == OP_ACC) || (io_op == OP_LOAD));
    assign w_acc_opnd  = w_clr ? {WIDTH{1'b0}} : r_acc;

    adder_pipe_acc_alu #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_alu (
        .i_op    (io_op),
        .i_in0   (io_in0),
        .i_in1   (io_in1),
        .i_acc   (w_acc_opnd),
        .o_res   (w_res),
        .o_carry (w_carry)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_carry     <= 1'b0;
            r_acc       <= '0;
            r_count     <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out       <= w_res;
                r_carry     <= w_carry;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end

            if (w_acc_wr)
                r_acc <= w_res;
            else if (w_clr)
                r_acc <= '0;

            // A handshake coinciding with clear is dropped, not counted.
            if (w_clr)
                r_count <= '0;
            else if (w_out_hs && (r_count != CNT_MAX))
                r_count <= r_count + 1'b1;
        end
    end

    assign io_out_valid = r_out_valid;
    assign io_out       = r_out;
    assign io_carry     = r_carry;
    assign io_ovf       = r_carry;
    assign io_acc       = r_acc;
    assign io_count     = r_count;

`ifndef SYNTHESIS
    logic [WIDTH-1:0] r_trc_a;
    logic [WIDTH-1:0] r_trc_b;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_trc_a <= '0;
            r_trc_b <= '0;
        end else if (w_accept) begin
            r_trc_a <= io_in0;
            r_trc_b <= io_in1;
        end
    end

    // r_out_valid is forced low in reset, so a handshake implies reset is released.
    always @(posedge clock) begin
        if (w_out_hs)
            $display("AdderPipeAcc: op %d %d := %d c=%d",
                     r_trc_a, r_trc_b, r_out, r_carry);
    end
`endif
endmodule
